// File: rtl/systolic_kernel_nxm.sv
// ROWS x COLS tap systolic kernel: a weight stream loads W[r][c], then samples are streamed
// and result(n) = sum W[r][c] * X_r[n-c] is produced two cycles after each accepted beat.
//
// state | meaning
// IDLE  | after reset, waiting for load_start
// LOAD  | accepting ROWS*COLS weights, row-major
// RUN   | accepting sample beats, producing results
module systolic_kernel_nxm #(
   parameter int DATA_W = 8,
   parameter int ROWS   = 2,
   parameter int COLS   = 2,
   localparam int RES_W = 2*DATA_W + $clog2(ROWS*COLS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_start,
   input  logic                     w_valid,
   input  logic [DATA_W-1:0]        w_data,
   output logic                     w_ready,
   input  logic                     in_valid,
   input  logic [ROWS*DATA_W-1:0]   in_vec,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [RES_W-1:0]         result,
   output logic                     busy
);

   localparam int N_W    = ROWS*COLS;
   localparam int WCNT_W = $clog2(N_W) + 1;
   localparam int WARM_W = $clog2(COLS) + 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   w_mem [N_W];
   logic [DATA_W-1:0]   taps  [ROWS][COLS];
   logic [WCNT_W-1:0]   w_cnt;
   logic [WARM_W-1:0]   warm_cnt;
   logic                p1_valid, p1_emit;
   logic [RES_W-1:0]    sum_c;
   logic                accept_w, accept_x, last_w;

   assign accept_w = (state_q == LOAD) && w_valid && !load_start;
   assign last_w   = accept_w && (w_cnt == WCNT_W'(N_W-1));
   assign accept_x = (state_q == RUN) && in_valid && !load_start;
   assign busy     = (state_q == LOAD) || ((state_q == RUN) && p1_valid);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      w_ready  = 1'b0;
      in_ready = 1'b0;
      case (state_q)
         IDLE: ;
         LOAD: begin
            w_ready = 1'b1;
            if (last_w) state_d = RUN;
         end
         RUN:  in_ready = 1'b1;
         default: state_d = IDLE;
      endcase
      if (load_start) state_d = LOAD;
   end

   // Taps hold X_r[n-c] after beat n, so the sum is formed one cycle after the beat.
   always_comb begin
      sum_c = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            sum_c = sum_c + RES_W'({{DATA_W{1'b0}}, w_mem[r*COLS+c]} *
                                   {{DATA_W{1'b0}}, taps[r][c]});
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_W; i++) w_mem[i] <= '0;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) taps[r][c] <= '0;
         w_cnt     <= '0;
         warm_cnt  <= '0;
         p1_valid  <= 1'b0;
         p1_emit   <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
      end else if (load_start) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) taps[r][c] <= '0;
         w_cnt     <= '0;
         warm_cnt  <= WARM_W'(COLS-1);
         p1_valid  <= 1'b0;
         p1_emit   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         p1_valid  <= accept_x;
         p1_emit   <= accept_x && (warm_cnt == '0);
         out_valid <= p1_emit;
         if (p1_emit) result <= sum_c;
         if (accept_w) begin
            for (int i = 0; i < N_W; i++)
               if (w_cnt == WCNT_W'(i)) w_mem[i] <= w_data;
            if (!last_w) w_cnt <= w_cnt + 1'b1;
         end
         // Down-counter for warm-up; outputs are enabled once it reaches terminal count.
         if (accept_x) begin
            for (int r = 0; r < ROWS; r++) begin
               taps[r][0] <= in_vec[r*DATA_W +: DATA_W];
               for (int c = 1; c < COLS; c++) taps[r][c] <= taps[r][c-1];
            end
            if (warm_cnt != '0) warm_cnt <= warm_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_systolic_kernel_nxm.sv
// Directed bench for systolic_kernel_nxm at DATA_W=8, ROWS=COLS=2 with hand-computed results.
module tb_systolic_kernel_nxm;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_start = 1'b0;
   logic        w_valid = 1'b0;
   logic [7:0]  w_data = '0;
   logic        in_valid = 1'b0;
   logic [15:0] in_vec = '0;
   logic        w_ready, in_ready, out_valid, busy;
   logic [17:0] result;

   int          cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;
   int          ov_cyc[$];
   logic [17:0] ov_res[$];

   systolic_kernel_nxm #(.DATA_W(8), .ROWS(2), .COLS(2)) dut (
      .clk(clk), .rst(rst), .load_start(load_start),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
      .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready),
      .out_valid(out_valid), .result(result), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         ov_cyc.push_back(cyc);
         ov_res.push_back(result);
      end
   end

   function automatic int get_cyc(int i);
      return (ov_cyc.size() > i) ? ov_cyc[i] : -1;
   endfunction

   function automatic logic [17:0] get_res(int i);
      return (ov_res.size() > i) ? ov_res[i] : 18'h3ffff;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      ov_cyc.delete();
      ov_res.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; load_start = 1'b0; w_valid = 1'b0; in_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic load_w(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
      logic [7:0] w [4];
      w[0] = a; w[1] = b; w[2] = c; w[3] = d;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w_valid = 1'b1; w_data = w[i];
         tick();
      end
      w_valid = 1'b0;
   endtask

   task automatic beat(input logic [7:0] r0, input logic [7:0] r1, output int bc);
      in_valid = 1'b1; in_vec = {r1, r0};
      bc = cyc;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
      n_total++; if (result !== 18'd0) $display("FAIL reset_result got %0d want 0", result); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_total++; if (w_ready !== 1'b0) $display("FAIL reset_w_ready got %b want 0", w_ready); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
      clear_log();
      repeat (5) tick();
      in_valid = 1'b0;
      tick();
      n_total++; if (ov_cyc.size() != 0) $display("FAIL idle_no_output got %0d outputs want 0", ov_cyc.size()); else n_pass++;
   endtask

   task automatic test_load_run();
      int b0, b1, b2;
      do_reset();
      load_w(8'd1, 8'd2, 8'd3, 8'd4);
      clear_log();
      beat(8'd1, 8'd5, b0); beat(8'd2, 8'd6, b1); beat(8'd3, 8'd7, b2);
      repeat (4) tick();
      @(negedge clk);
      n_total++; if (ov_cyc.size() != 2) $display("FAIL run_count got %0d want 2", ov_cyc.size()); else n_pass++;
      n_total++; if (get_cyc(0) != b1 + 2) $display("FAIL run_cyc0 got %0d want %0d", get_cyc(0), b1 + 2); else n_pass++;
      n_total++; if (get_res(0) !== 18'd42) $display("FAIL run_res0 got %0d want 42", get_res(0)); else n_pass++;
      n_total++; if (get_cyc(1) != b2 + 2) $display("FAIL run_cyc1 got %0d want %0d", get_cyc(1), b2 + 2); else n_pass++;
      n_total++; if (get_res(1) !== 18'd52) $display("FAIL run_res1 got %0d want 52", get_res(1)); else n_pass++;
      n_total++; if (result !== 18'd52) $display("FAIL run_hold got %0d want 52", result); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL run_in_ready got %b want 1", in_ready); else n_pass++;
   endtask

   task automatic test_stall();
      int b0, b1, b2;
      do_reset();
      load_w(8'd1, 8'd2, 8'd3, 8'd4);
      clear_log();
      beat(8'd1, 8'd5, b0); beat(8'd2, 8'd6, b1);
      repeat (3) tick();
      beat(8'd3, 8'd7, b2);
      repeat (4) tick();
      n_total++; if (ov_cyc.size() != 2) $display("FAIL stall_count got %0d want 2", ov_cyc.size()); else n_pass++;
      n_total++; if (get_cyc(0) != b1 + 2) $display("FAIL stall_cyc0 got %0d want %0d", get_cyc(0), b1 + 2); else n_pass++;
      n_total++; if (get_res(0) !== 18'd42) $display("FAIL stall_res0 got %0d want 42", get_res(0)); else n_pass++;
      n_total++; if (get_cyc(1) != b2 + 2) $display("FAIL stall_cyc1 got %0d want %0d", get_cyc(1), b2 + 2); else n_pass++;
      n_total++; if (get_res(1) !== 18'd52) $display("FAIL stall_res1 got %0d want 52", get_res(1)); else n_pass++;
   endtask

   task automatic test_max_width();
      int b0, b1;
      do_reset();
      load_w(8'd255, 8'd255, 8'd255, 8'd255);
      clear_log();
      beat(8'd255, 8'd255, b0); beat(8'd255, 8'd255, b1);
      repeat (4) tick();
      n_total++; if (ov_cyc.size() != 1) $display("FAIL max_count got %0d want 1", ov_cyc.size()); else n_pass++;
      n_total++; if (get_res(0) !== 18'd260100) $display("FAIL max_res got %0d want 260100", get_res(0)); else n_pass++;
      n_total++; if (get_cyc(0) != b1 + 2) $display("FAIL max_cyc got %0d want %0d", get_cyc(0), b1 + 2); else n_pass++;
   endtask

   task automatic test_reload();
      int b0, b1, b2, b3, b4, b5;
      do_reset();
      load_w(8'd1, 8'd2, 8'd3, 8'd4);
      clear_log();
      beat(8'd1, 8'd5, b0); beat(8'd2, 8'd6, b1); beat(8'd3, 8'd7, b2); beat(8'd4, 8'd8, b3);
      load_w(8'd0, 8'd0, 8'd0, 8'd1);
      n_total++; if (ov_cyc.size() != 2) $display("FAIL reload_discard got %0d outputs want 2", ov_cyc.size()); else n_pass++;
      n_total++; if (get_cyc(1) != b3 + 1) $display("FAIL reload_last_cyc got %0d want %0d", get_cyc(1), b3 + 1); else n_pass++;
      clear_log();
      beat(8'd0, 8'd9, b4); beat(8'd0, 8'd8, b5);
      repeat (4) tick();
      n_total++; if (ov_cyc.size() != 1) $display("FAIL reload_count got %0d want 1", ov_cyc.size()); else n_pass++;
      n_total++; if (get_res(0) !== 18'd9) $display("FAIL reload_res got %0d want 9", get_res(0)); else n_pass++;
      n_total++; if (get_cyc(0) != b5 + 2) $display("FAIL reload_cyc got %0d want %0d", get_cyc(0), b5 + 2); else n_pass++;
   endtask

   task automatic test_reset_mid_load();
      int b0, b1, b2;
      do_reset();
      load_start = 1'b1; tick(); load_start = 1'b0;
      w_valid = 1'b1; w_data = 8'd9; tick();
      w_data = 8'd7; tick();
      w_valid = 1'b0;
      @(negedge clk);
      n_total++; if (w_ready !== 1'b1) $display("FAIL load_w_ready got %b want 1", w_ready); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL load_busy got %b want 1", busy); else n_pass++;
      rst = 1'b1; tick(); rst = 1'b0;
      @(negedge clk);
      n_total++; if (w_ready !== 1'b0) $display("FAIL midload_w_ready got %b want 0", w_ready); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL midload_busy got %b want 0", busy); else n_pass++;
      load_w(8'd1, 8'd2, 8'd3, 8'd4);
      clear_log();
      beat(8'd1, 8'd5, b0); beat(8'd2, 8'd6, b1); beat(8'd3, 8'd7, b2);
      repeat (4) tick();
      n_total++; if (get_res(0) !== 18'd42) $display("FAIL midload_res0 got %0d want 42", get_res(0)); else n_pass++;
      n_total++; if (get_res(1) !== 18'd52) $display("FAIL midload_res1 got %0d want 52", get_res(1)); else n_pass++;
      n_total++; if (ov_cyc.size() != 2) $display("FAIL midload_count got %0d want 2", ov_cyc.size()); else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      int b0, b1;
      do_reset();
      load_w(8'd1, 8'd2, 8'd3, 8'd4);
      clear_log();
      beat(8'd1, 8'd5, b0); beat(8'd2, 8'd6, b1);
      rst = 1'b1; tick(); rst = 1'b0;
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0) $display("FAIL midrun_out_valid got %b want 0", out_valid); else n_pass++;
      n_total++; if (result !== 18'd0) $display("FAIL midrun_result got %0d want 0", result); else n_pass++;
      repeat (3) tick();
      n_total++; if (ov_cyc.size() != 0) $display("FAIL midrun_count got %0d want 0", ov_cyc.size()); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_load_run();
      test_stall();
      test_max_width();
      test_reload();
      test_reset_mid_load();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/systolic_kernel_nxm.md
SYSTOLIC_KERNEL_NXM -- requirements
Module: systolic_kernel_nxm

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each unsigned input sample and weight.
REQ-002 SHALL have parameter ROWS, default 2: number of input rows (PE chains), legal range 1..8.
REQ-003 SHALL have parameter COLS, default 2: number of taps per row, legal range 1..8.
REQ-004 SHALL have derived localparam RES_W = 2*DATA_W + clog2(ROWS*COLS), with clog2(1)=0.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port load_start, input, 1: one-cycle pulse that starts a weight load.
REQ-008 SHALL have port w_valid, input, 1, and port w_data, input, DATA_W: weight stream.
REQ-009 SHALL have port w_ready, output, 1: high only in LOAD.
REQ-010 SHALL have port in_valid, input, 1, and port in_vec, input, ROWS*DATA_W: one sample per row per beat; row r occupies bits [r*DATA_W +: DATA_W].
REQ-011 SHALL have port in_ready, output, 1: high only in RUN.
REQ-012 SHALL have ports out_valid, output, 1, and result, output, RES_W: kernel output.
REQ-013 SHALL have port busy, output, 1: high in LOAD, or in RUN while any accepted beat is still in the pipeline.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, LOAD, RUN.
REQ-015 SHALL move from any state to LOAD on load_start; load_start takes priority over every other input in the same cycle.
REQ-016 SHALL, in LOAD, store w_data on each w_valid beat into W[r][c] in row-major order (c fastest), using a counter that starts at 0 on entry.
REQ-017 SHALL move from LOAD to RUN in the cycle after the ROWS*COLS-th weight is accepted; the weight counter SHALL NOT wrap.
REQ-018 SHALL, on every entry to LOAD, clear the tap history, the warm-up counter and all in-flight pipeline valids; w_valid outside LOAD SHALL be ignored.
REQ-019 SHALL, in RUN, accept sample n on every cycle with in_valid=1; in_valid=0 SHALL stall the tap shift (no bubble inserted into the history).
REQ-020 SHALL compute result(n) = sum over r,c of W[r][c]*X_r[n-c], unsigned and full precision, with no truncation or saturation.
REQ-021 SHALL suppress outputs during warm-up: no out_valid for samples n < COLS-1 after entering RUN.
REQ-022 SHALL assert out_valid for exactly one cycle, two cycles after the accepted beat of sample n (beat at cycle t gives out_valid at t+2), with result valid in that cycle.
REQ-023 SHALL hold result at its last value while out_valid=0.
REQ-024 SHALL ignore in_valid in IDLE and LOAD.
REQ-025 SHALL leave RUN only by load_start or rst.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, go to IDLE and clear to 0: all weights, tap history, the weight counter, the warm-up counter, pipeline valids, result, out_valid, busy, w_ready and in_ready.
REQ-027 SHALL, on reset asserted mid-LOAD or mid-RUN, discard all in-flight results; no out_valid in the cycle after reset.

Verification
REQ-028 Reset: after rst, outputs all 0 and state IDLE; in_valid=1 for 5 cycles -> out_valid stays 0.
REQ-029 Load and run, ROWS=COLS=2, DATA_W=8: load 1,2,3,4; stream rows (1,5),(2,6),(3,7) back-to-back -> out_valid on two cycles only, result 42 then 52.
REQ-030 Stall: same stimulus with in_valid low for 3 cycles between beats 2 and 3 -> same results 42 and 52, each out_valid exactly 2 cycles after its beat.
REQ-031 Max width: all weights and samples 255 -> result 260100 with no overflow (RES_W=18).
REQ-032 Reload mid-stream: load_start one cycle after a RUN beat -> no out_valid for that beat; after new weights 0,0,0,1, stream (0,9),(0,8) -> result 9.
REQ-033 Reset mid-LOAD: rst after 2 of 4 weights, then a full load of 1,2,3,4 -> results identical to the load-and-run scenario (REQ-029).
